// File: rtl/scan_pkg.sv
// Shared types and constants for the scan controller and its coordinate generator.
package scan_pkg;

  localparam int MAX_LOG2 = 5;

  typedef enum logic [1:0] {
    SCAN_DIAG = 2'd0,
    SCAN_HOR  = 2'd1,
    SCAN_VER  = 2'd2,
    SCAN_RSVD = 2'd3
  } scan_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gen_state_e;

  function automatic logic [2:0] clamp_log2(input logic [2:0] l2);
    return (l2 > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : l2;
  endfunction

endpackage

// File: rtl/scan_next_coord.sv
// Combinational step of a scan walk: current (x, y) to the following in-block position.
// Output at the final position of a block is unused by the caller.
module scan_next_coord
  import scan_pkg::*;
#(
  parameter int COORD_W = MAX_LOG2
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] w_m1,
  input  logic [COORD_W-1:0] h_m1,
  input  scan_type_e         scan_type,
  output logic [COORD_W-1:0] next_x,
  output logic [COORD_W-1:0] next_y
);

  logic [COORD_W:0]   d_next;
  logic [COORD_W-1:0] y0;

  always_comb begin
    d_next = {1'b0, x} + {1'b0, y} + (COORD_W+1)'(1);
    // New up-right diagonal starts on the lowest row it can reach inside the block.
    y0     = (d_next > {1'b0, h_m1}) ? h_m1 : d_next[COORD_W-1:0];
    next_x = x;
    next_y = y;
    case (scan_type)
      SCAN_HOR: begin
        if (x == w_m1) begin
          next_x = '0;
          next_y = y + COORD_W'(1);
        end else begin
          next_x = x + COORD_W'(1);
        end
      end
      SCAN_VER: begin
        if (y == h_m1) begin
          next_y = '0;
          next_x = x + COORD_W'(1);
        end else begin
          next_y = y + COORD_W'(1);
        end
      end
      default: begin
        if (y == '0 || x == w_m1) begin
          next_y = y0;
          next_x = d_next[COORD_W-1:0] - y0;
        end else begin
          next_x = x + COORD_W'(1);
          next_y = y - COORD_W'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/scan_coord_gen.sv
// Streams one (x, y) coordinate per accepted beat over a transform block; first beat one cycle after start.
// Outputs hold while coord_ready is low; done pulses for one cycle after the last beat is accepted.
module scan_coord_gen
  import scan_pkg::*;
#(
  parameter int POS_W   = 2*MAX_LOG2,
  parameter int COORD_W = MAX_LOG2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         log2BlockWidth,
  input  logic [2:0]         log2BlockHeight,
  input  logic [1:0]         scanType,
  input  logic               coord_ready,
  output logic               coord_valid,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [POS_W-1:0]   scan_idx,
  output logic               last,
  output logic               busy,
  output logic               done
);

  gen_state_e         state;
  scan_type_e         stype;
  logic [COORD_W-1:0] w_m1, h_m1;
  logic [POS_W-1:0]   n_m1;

  logic [2:0]         lw, lh;
  logic [3:0]         lsum;
  logic [COORD_W-1:0] w_m1_in, h_m1_in;
  logic [POS_W-1:0]   n_m1_in;
  logic [POS_W-1:0]   idx_inc;
  logic [COORD_W-1:0] nx, ny;
  logic               accept;

  // Block size minus one as a low-bit mask; a full-width shift leaves all ones.
  assign lw      = clamp_log2(log2BlockWidth);
  assign lh      = clamp_log2(log2BlockHeight);
  assign lsum    = {1'b0, lw} + {1'b0, lh};
  assign w_m1_in = ~({COORD_W{1'b1}} << lw);
  assign h_m1_in = ~({COORD_W{1'b1}} << lh);
  assign n_m1_in = ~({POS_W{1'b1}} << lsum);
  assign idx_inc = scan_idx + POS_W'(1);
  assign accept  = coord_valid && coord_ready;

  scan_next_coord #(
    .COORD_W (COORD_W)
  ) u_next (
    .x         (pos_x),
    .y         (pos_y),
    .w_m1      (w_m1),
    .h_m1      (h_m1),
    .scan_type (stype),
    .next_x    (nx),
    .next_y    (ny)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      coord_valid <= 1'b0;
      last        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pos_x       <= '0;
      pos_y       <= '0;
      scan_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            w_m1        <= w_m1_in;
            h_m1        <= h_m1_in;
            n_m1        <= n_m1_in;
            stype       <= scan_type_e'(scanType);
            pos_x       <= '0;
            pos_y       <= '0;
            scan_idx    <= '0;
            last        <= (n_m1_in == '0);
            coord_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (last) begin
              coord_valid <= 1'b0;
              last        <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              pos_x    <= nx;
              pos_y    <= ny;
              scan_idx <= idx_inc;
              last     <= (idx_inc == n_m1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_coord_gen.sv
// Randomized bench for scan_coord_gen against a list-based scan-order model and a per-cycle phase model.
module tb_scan_coord_gen;
  import scan_pkg::*;

  localparam int POS_W   = 10;
  localparam int COORD_W = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [2:0]         log2BlockWidth = '0;
  logic [2:0]         log2BlockHeight = '0;
  logic [1:0]         scanType = '0;
  logic               coord_ready = 1'b0;
  logic               coord_valid;
  logic [COORD_W-1:0] pos_x, pos_y;
  logic [POS_W-1:0]   scan_idx;
  logic               last, busy, done;

  scan_coord_gen #(.POS_W(POS_W), .COORD_W(COORD_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .log2BlockWidth  (log2BlockWidth),
    .log2BlockHeight (log2BlockHeight),
    .scanType        (scanType),
    .coord_ready     (coord_ready),
    .coord_valid     (coord_valid),
    .pos_x           (pos_x),
    .pos_y           (pos_y),
    .scan_idx        (scan_idx),
    .last            (last),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected scan order, built by plain enumeration of the block.
  int exp_x[$];
  int exp_y[$];

  function automatic void build_exp(input int l2w, input int l2h, input int typ);
    int w, h, y_hi;
    w = 1 << ((l2w > MAX_LOG2) ? MAX_LOG2 : l2w);
    h = 1 << ((l2h > MAX_LOG2) ? MAX_LOG2 : l2h);
    exp_x.delete();
    exp_y.delete();
    if (typ == 1) begin
      for (int yy = 0; yy < h; yy++)
        for (int xx = 0; xx < w; xx++) begin exp_x.push_back(xx); exp_y.push_back(yy); end
    end else if (typ == 2) begin
      for (int xx = 0; xx < w; xx++)
        for (int yy = 0; yy < h; yy++) begin exp_x.push_back(xx); exp_y.push_back(yy); end
    end else begin
      for (int d = 0; d <= w + h - 2; d++) begin
        y_hi = (d < h - 1) ? d : h - 1;
        for (int yy = y_hi; yy >= 0; yy--) begin
          if (d - yy < w) begin exp_x.push_back(d - yy); exp_y.push_back(yy); end
        end
      end
    end
  endfunction

  // Phase model: 0 idle, 1 streaming, 2 done cycle.
  int  phase = 0;
  int  idx = 0;
  bit  chk_en = 0;
  bit  just_started = 0;
  int  cyc = 0;
  int  scan_cnt = 0;
  int  done_cnt = 0;
  int  start_cyc = 0, first_valid_cyc = 0, done_cyc = 0, restart_gap = 0;
  int  last_x = 0, last_y = 0, last_idx = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (chk_en) begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      case (phase)
        0: begin
          check("idle.valid", coord_valid, 0);
          check("idle.busy", busy, 0);
          check("idle.done", done, 0);
        end
        1: begin
          if (just_started) begin
            first_valid_cyc = cyc;
            restart_gap = cyc - done_cyc;
            just_started = 0;
          end
          check("run.valid", coord_valid, 1);
          check("run.busy", busy, 1);
          check("run.done", done, 0);
          check("run.x", pos_x, exp_x[idx]);
          check("run.y", pos_y, exp_y[idx]);
          check("run.idx", scan_idx, idx);
          check("run.last", last, (idx == exp_x.size() - 1) ? 1 : 0);
        end
        default: begin
          check("done.valid", coord_valid, 0);
          check("done.busy", busy, 1);
          check("done.pulse", done, 1);
        end
      endcase
      if (rst) begin
        phase = 0;
        idx = 0;
      end else begin
        case (phase)
          0: if (start) begin
            build_exp(log2BlockWidth, log2BlockHeight, scanType);
            idx = 0;
            start_cyc = cyc;
            just_started = 1;
            phase = 1;
          end
          1: if (coord_ready) begin
            if (idx == exp_x.size() - 1) begin
              last_x = pos_x; last_y = pos_y; last_idx = scan_idx;
              phase = 2;
            end else idx++;
          end
          default: begin phase = 0; scan_cnt++; end
        endcase
      end
    end
  end

  function automatic logic pick_ready(input int mode);
    if (mode == 0) return 1'b1;
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic run_scan(input int l2w, input int l2h, input int typ, input int mode);
    int s0, budget;
    s0 = scan_cnt;
    budget = 4 * (1 << (((l2w > 5) ? 5 : l2w) + ((l2h > 5) ? 5 : l2h))) + 50;
    @(posedge clk); #1;
    log2BlockWidth = 3'(l2w);
    log2BlockHeight = 3'(l2h);
    scanType = 2'(typ);
    start = 1'b1;
    coord_ready = pick_ready(mode);
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the size inputs: the captured values must be the ones used.
    log2BlockWidth = 3'($urandom_range(0, 7));
    log2BlockHeight = 3'($urandom_range(0, 7));
    scanType = 2'($urandom_range(0, 3));
    for (int c = 0; c < budget && scan_cnt == s0; c++) begin
      coord_ready = pick_ready(mode);
      @(posedge clk); #1;
    end
    check("scan_complete", (scan_cnt > s0) ? 1 : 0, 1);
  endtask

  int d0, s0;

  initial begin
    // Model pins: hand-enumerated orders.
    begin
      int dx[7] = '{0, 0, 1, 0, 1, 2, 0};
      int dy[7] = '{0, 1, 0, 2, 1, 0, 3};
      int hx[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int hy[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
      build_exp(2, 2, 0);
      check("pin.diag4.size", exp_x.size(), 16);
      for (int i = 0; i < 7; i++) begin
        check("pin.diag4.x", exp_x[i], dx[i]);
        check("pin.diag4.y", exp_y[i], dy[i]);
      end
      check("pin.diag4.endx", exp_x[15], 3);
      check("pin.diag4.endy", exp_y[15], 3);
      build_exp(3, 1, 0);
      check("pin.diag82.x4", exp_x[4], 2);
      check("pin.diag82.y3", exp_y[3], 1);
      check("pin.diag82.x14", exp_x[14], 7);
      check("pin.diag82.y15", exp_y[15], 1);
      build_exp(2, 1, 1);
      for (int i = 0; i < 8; i++) begin
        check("pin.hor.x", exp_x[i], hx[i]);
        check("pin.hor.y", exp_y[i], hy[i]);
      end
      build_exp(1, 2, 2);
      for (int i = 0; i < 8; i++) begin
        check("pin.ver.x", exp_x[i], hy[i]);
        check("pin.ver.y", exp_y[i], hx[i]);
      end
      build_exp(7, 7, 3);
      check("pin.clamp.size", exp_x.size(), 1024);
      check("pin.clamp.endx", exp_x[1023], 31);
      build_exp(0, 0, 0);
      check("pin.1x1.size", exp_x.size(), 1);
    end

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset.valid", coord_valid, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.last", last, 0);
    check("reset.x", pos_x, 0);
    check("reset.y", pos_y, 0);
    check("reset.idx", scan_idx, 0);
    chk_en = 1;

    // DIAG 4x4, ready tied high: first beat one cycle, done seventeen cycles after start.
    run_scan(2, 2, 0, 0);
    check("diag4.first_valid_lat", first_valid_cyc - start_cyc, 1);
    check("diag4.done_lat", done_cyc - start_cyc, 17);
    check("diag4.last_idx", last_idx, 15);
    run_scan(3, 1, 0, 0);
    check("diag82.last_x", last_x, 7);
    check("diag82.last_y", last_y, 1);
    run_scan(2, 1, 1, 1);
    run_scan(1, 2, 2, 1);
    d0 = done_cnt;
    run_scan(0, 0, 0, 0);
    check("1x1.done_lat", done_cyc - start_cyc, 2);
    run_scan(0, 0, 2, 1);
    check("1x1.done_count", done_cnt - d0, 2);
    run_scan(7, 7, 0, 0);
    check("clamp.last_x", last_x, 31);
    check("clamp.last_y", last_y, 31);
    check("clamp.last_idx", last_idx, 1023);

    // Reset while beat 5 of a 16x16 scan is on the bus.
    d0 = done_cnt;
    @(posedge clk); #1;
    log2BlockWidth = 3'd4; log2BlockHeight = 3'd4; scanType = 2'd0;
    start = 1'b1; coord_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst.mid_idx", scan_idx, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst.valid", coord_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.idx", scan_idx, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst.no_done", done_cnt - d0, 0);
    run_scan(4, 4, 1, 1);

    // Start held high through a whole scan and its done cycle.
    d0 = done_cnt;
    s0 = scan_cnt;
    @(posedge clk); #1;
    log2BlockWidth = 3'd1; log2BlockHeight = 3'd1; scanType = 2'd0;
    start = 1'b1; coord_ready = 1'b1;
    for (int c = 0; c < 100 && scan_cnt == s0; c++) begin @(posedge clk); #1; end
    check("hold.first_scan", (scan_cnt > s0) ? 1 : 0, 1);
    @(posedge clk); #1;
    start = 1'b0;
    check("hold.one_done", done_cnt - d0, 1);
    for (int c = 0; c < 100 && scan_cnt == s0 + 1; c++) begin @(posedge clk); #1; end
    check("hold.second_scan", scan_cnt - s0, 2);
    check("hold.restart_gap", restart_gap, 2);
    check("hold.two_done", done_cnt - d0, 2);

    // Random blocks, orders and backpressure.
    for (int t = 0; t < 10; t++)
      run_scan($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3), 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
